// File: rtl/dma_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_fifo_ctrl_if
// Description : Requester handshakes, FIFO control lines and status flags
//               shared between the DMA engines and the FIFO access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_fifo_ctrl_if #(
    parameter int DATA      = 8,
    parameter int ADDR_SIZE = 4
);
    logic                 wr_req;
    logic [DATA-1:0]      wr_data;
    logic                 wr_ack;
    logic                 rd_req;
    logic                 rd_ack;
    logic [DATA-1:0]      rd_data;
    logic                 fifo_enable;
    logic                 fifo_wr_rd;
    logic                 fifo_old_add_flag;
    logic [DATA-1:0]      fifo_in;
    logic [DATA-1:0]      fifo_out;
    logic                 full;
    logic                 empty;
    logic [ADDR_SIZE:0]   level;
    logic                 above_hi;
    logic                 below_lo;
    logic                 busy;

    modport slave (
        input  wr_req, wr_data, rd_req, fifo_out, full, empty,
        output wr_ack, rd_ack, rd_data, fifo_enable, fifo_wr_rd,
               fifo_old_add_flag, fifo_in, level, above_hi, below_lo, busy
    );

    modport master (
        output wr_req, wr_data, rd_req, fifo_out, full, empty,
        input  wr_ack, rd_ack, rd_data, fifo_enable, fifo_wr_rd,
               fifo_old_add_flag, fifo_in, level, above_hi, below_lo, busy
    );
endinterface
`default_nettype wire

// File: rtl/dma_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_fifo_ctrl
// Description : Round-robin single-port FIFO access sequencer with occupancy
//               count and watermark flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_fifo_ctrl #(
    parameter int DATA      = 8,
    parameter int ADDR_SIZE = 4,
    parameter int HI_WM     = 12,
    parameter int LO_WM     = 4
) (
    input  logic            clk,
    input  logic            rst,
    dma_fifo_ctrl_if.slave  bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [ADDR_SIZE:0] c_HI_WM = HI_WM[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] c_LO_WM = LO_WM[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] c_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_last_wr;
    logic                 r_wr_rd;
    logic [DATA-1:0]      r_fifo_in;
    logic [DATA-1:0]      r_rd_data;
    logic [ADDR_SIZE:0]   r_level;
    logic [ADDR_SIZE:0]   w_level_next;
    logic                 r_above_hi;
    logic                 r_below_lo;

    logic                 w_wr_elig;
    logic                 w_rd_elig;
    logic                 w_grant;
    logic                 w_grant_wr;
    logic                 w_fifo_enable;
    logic                 w_wr_ack;
    logic                 w_rd_ack;
    logic                 w_busy;

    assign w_wr_elig  = (r_state == c_IDLE) && bus.wr_req && !bus.full  && !w_wr_ack;
    assign w_rd_elig  = (r_state == c_IDLE) && bus.rd_req && !bus.empty && !w_rd_ack;
    assign w_grant    = w_wr_elig || w_rd_elig;
    // On a tie the requester not served last wins.
    assign w_grant_wr = w_wr_elig && (!w_rd_elig || !r_last_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (w_grant) w_state_next = c_SETUP;
            c_SETUP:  w_state_next = c_ACCESS;
            c_ACCESS: w_state_next = c_RESP;
            c_RESP:   w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_fifo_enable = 1'b0;
        w_wr_ack      = 1'b0;
        w_rd_ack      = 1'b0;
        w_busy        = (r_state != c_IDLE);
        case (r_state)
            c_ACCESS: w_fifo_enable = 1'b1;
            c_RESP: begin
                w_wr_ack = r_wr_rd;
                w_rd_ack = !r_wr_rd;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_level_next = r_level;
        if (r_state == c_ACCESS) begin
            w_level_next = r_wr_rd ? (r_level + c_ONE) : (r_level - c_ONE);
        end
    end

    // Direction only moves on a grant so it is settled a full cycle before enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_wr  <= 1'b0;
            r_wr_rd    <= 1'b0;
            r_fifo_in  <= '0;
            r_rd_data  <= '0;
            r_level    <= '0;
            r_above_hi <= 1'b0;
            r_below_lo <= 1'b1;
        end else begin
            if (w_grant) begin
                r_wr_rd   <= w_grant_wr;
                r_last_wr <= w_grant_wr;
                if (w_grant_wr) begin
                    r_fifo_in <= bus.wr_data;
                end
            end
            if ((r_state == c_ACCESS) && !r_wr_rd) begin
                r_rd_data <= bus.fifo_out;
            end
            r_level    <= w_level_next;
            r_above_hi <= (w_level_next >= c_HI_WM);
            r_below_lo <= (w_level_next <= c_LO_WM);
        end
    end

    assign bus.fifo_enable       = w_fifo_enable;
    assign bus.fifo_wr_rd        = r_wr_rd;
    assign bus.fifo_old_add_flag = 1'b0;
    assign bus.fifo_in           = r_fifo_in;
    assign bus.wr_ack            = w_wr_ack;
    assign bus.rd_ack            = w_rd_ack;
    assign bus.rd_data           = r_rd_data;
    assign bus.level             = r_level;
    assign bus.above_hi          = r_above_hi;
    assign bus.below_lo          = r_below_lo;
    assign bus.busy              = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_dma_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_fifo_ctrl
// Description : Self-checking bench for dma_fifo_ctrl with a FIFO model,
//               transaction scoreboard and access-protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_fifo_ctrl;
    localparam int c_DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_fifo_ctrl_if #(.DATA(8), .ADDR_SIZE(4)) bus ();

    dma_fifo_ctrl #(.DATA(8), .ADDR_SIZE(4), .HI_WM(12), .LO_WM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fmem[$];

    int   ph = 0;
    int   ml = 0;
    logic exp_dir   = 1'b0;
    logic m_last_wr = 1'b0;
    logic p_we = 1'b0;
    logic p_re = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port FIFO, serviced mid-cycle to avoid edge races.
    always @(negedge clk) begin
        if (rst) begin
            fmem.delete();
        end else if (bus.fifo_enable) begin
            if (bus.fifo_wr_rd) begin
                if (fmem.size() < c_DEPTH) fmem.push_back(bus.fifo_in);
            end else if (fmem.size() > 0) begin
                bus.fifo_out = fmem.pop_front();
            end
        end
        bus.full  = (fmem.size() == c_DEPTH);
        bus.empty = (fmem.size() == 0);
    end

    // Protocol monitor and scoreboard: grant choice, SETUP/ACCESS/RESP timing,
    // read data order, occupancy and watermarks.
    always @(negedge clk) begin
        if (rst) begin
            ph = 0; ml = 0; m_last_wr = 1'b0; p_we = 1'b0; p_re = 1'b0;
        end else begin
            case (ph)
                0: begin
                    if (bus.busy) begin
                        chk("grant_valid", 32'(p_we || p_re), 1);
                        exp_dir = (p_we && p_re) ? !m_last_wr : p_we;
                        chk("grant_dir", 32'(bus.fifo_wr_rd), 32'(exp_dir));
                        chk("setup_enable", 32'(bus.fifo_enable), 0);
                        m_last_wr = exp_dir;
                        ph = 1;
                    end else begin
                        chk("idle_quiet", {29'd0, bus.fifo_enable, bus.wr_ack, bus.rd_ack}, 0);
                        p_we = bus.wr_req && !bus.full;
                        p_re = bus.rd_req && !bus.empty;
                    end
                end
                1: begin
                    chk("access_enable", 32'(bus.fifo_enable), 1);
                    chk("access_dir", 32'(bus.fifo_wr_rd), 32'(exp_dir));
                    ph = 2;
                end
                2: begin
                    chk("resp_enable", 32'(bus.fifo_enable), 0);
                    chk("resp_ack", {30'd0, bus.wr_ack, bus.rd_ack}, exp_dir ? 32'd2 : 32'd1);
                    chk("resp_dir", 32'(bus.fifo_wr_rd), 32'(exp_dir));
                    if (exp_dir) begin
                        ml++;
                    end else begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rd_data: got %0h expected none (scoreboard empty)", bus.rd_data);
                        end else begin
                            chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                        end
                        ml--;
                    end
                    chk("level", 32'(bus.level), 32'(ml));
                    chk("above_hi", 32'(bus.above_hi), 32'(ml >= 12));
                    chk("below_lo", 32'(bus.below_lo), 32'(ml <= 4));
                    ph = 3;
                end
                default: begin
                    chk("back_to_idle", {30'd0, bus.busy, bus.wr_ack | bus.rd_ack}, 0);
                    p_we = bus.wr_req && !bus.full;
                    p_re = bus.rd_req && !bus.empty;
                    ph = 0;
                end
            endcase
        end
    end

    task automatic write_word(input logic [7:0] d);
        int t = 0;
        @(posedge clk); #1;
        exp_q.push_back(d);
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        do begin @(negedge clk); t++; end while (!bus.wr_ack && t < 400);
        chk("wr_ack_seen", 32'(bus.wr_ack), 1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
    endtask

    task automatic read_word();
        int t = 0;
        @(posedge clk); #1;
        bus.rd_req = 1'b1;
        do begin @(negedge clk); t++; end while (!bus.rd_ack && t < 400);
        chk("rd_ack_seen", 32'(bus.rd_ack), 1);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_enable",   32'(bus.fifo_enable), 0);
        chk("rst_wr_rd",    32'(bus.fifo_wr_rd), 0);
        chk("rst_old_add",  32'(bus.fifo_old_add_flag), 0);
        chk("rst_fifo_in",  32'(bus.fifo_in), 0);
        chk("rst_rd_data",  32'(bus.rd_data), 0);
        chk("rst_acks",     {30'd0, bus.wr_ack, bus.rd_ack}, 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_level",    32'(bus.level), 0);
        chk("rst_above_hi", 32'(bus.above_hi), 0);
        chk("rst_below_lo", 32'(bus.below_lo), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_data = 8'h00;
        bus.fifo_out = 8'h00; bus.full = 1'b0; bus.empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Single write
        write_word(8'hA5);
        chk("t1_level", 32'(bus.level), 1);
        chk("t1_below_lo", 32'(bus.below_lo), 1);

        // Ordered data return
        do_reset();
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        repeat (3) read_word();
        chk("t2_level", 32'(bus.level), 0);

        // Both requesters held: grants alternate
        write_word(8'h40); write_word(8'h41);
        fork
            begin for (int i = 0; i < 4; i++) write_word(8'h50 + 8'(i)); end
            begin for (int i = 0; i < 4; i++) read_word(); end
        join
        chk("t3_level", 32'(bus.level), 2);
        repeat (2) read_word();

        // Full FIFO blocks a pending write until a read frees a slot
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'(i * 7 + 3));
        chk("t4_level", 32'(bus.level), 16);
        chk("t4_above_hi", 32'(bus.above_hi), 1);
        chk("t4_full", 32'(bus.full), 1);
        fork
            write_word(8'hEE);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("t4_blocked", {30'd0, bus.busy, bus.fifo_enable}, 0);
                end
                read_word();
            end
        join
        chk("t4_level_after", 32'(bus.level), 16);
        repeat (16) read_word();

        // Read on empty FIFO waits for a write
        do_reset();
        fork
            read_word();
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("t5_idle", {30'd0, bus.busy, bus.rd_ack}, 0);
                end
                write_word(8'h77);
            end
        join
        chk("t5_level", 32'(bus.level), 0);

        // Reset during ACCESS of a write aborts it
        begin
            int t = 0;
            @(posedge clk); #1;
            bus.wr_data = 8'h5A;
            bus.wr_req  = 1'b1;
            do begin @(negedge clk); t++; end while (!bus.fifo_enable && t < 50);
            chk("t6_reached_access", 32'(bus.fifo_enable), 1);
            rst = 1'b1;
            bus.wr_req = 1'b0;
            @(posedge clk); #1;
            check_reset_values();
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("t6_no_ack", {30'd0, bus.wr_ack, bus.busy}, 0);
        end

        // Randomized concurrent traffic
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    write_word(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    read_word();
                end
            end
        join
        repeat (2) @(negedge clk);
        chk("rand_level", 32'(bus.level), 0);
        chk("rand_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dma_fifo_ctrl.md
# dma_fifo_ctrl

Single-port access sequencer and arbiter for the DMA controller's `fifo` buffer. It accepts write requests from the memory-side engine and read requests from the peripheral-side engine, and grants them round-robin. For each granted access it drives `fifo_wr_rd` one full cycle before `fifo_enable`, so the FIFO register enables never see a direction change in the same cycle. It also keeps an occupancy count and watermark flags that the DMA FSM uses for burst decisions.

## Interface
- `DATA`, 8, FIFO word width
- `ADDR_SIZE`, 4, FIFO address width; depth = 2^ADDR_SIZE
- `HI_WM`, 12, `above_hi` asserts when level ≥ HI_WM
- `LO_WM`, 4, `below_lo` asserts when level ≤ LO_WM

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset; the same net also resets the FIFO
- `wr_req`  in  1  memory side: write request, held until `wr_ack`
- `wr_data`  in  DATA  write word, stable while `wr_req`=1
- `wr_ack`  out  1  one-cycle pulse, word committed
- `rd_req`  in  1  peripheral side: read request, held until `rd_ack`
- `rd_ack`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  DATA  last word read, held until the next read
- `fifo_enable`  out  1  to FIFO
- `fifo_wr_rd`  out  1  to FIFO; 1 = write, 0 = read
- `fifo_old_add_flag`  out  1  to FIFO; always 0 (replay reserved)
- `fifo_in`  out  DATA  to FIFO, registered copy of `wr_data`
- `fifo_out`  in  DATA  from FIFO
- `full`, `empty`  in  1  from FIFO
- `level`  out  ADDR_SIZE+1  occupancy count, 0..2^ADDR_SIZE
- `above_hi`, `below_lo`  out  1  watermark flags, registered
- `busy`  out  1  1 when the state is not IDLE

## Operation
- States: IDLE → SETUP → ACCESS → RESP → IDLE.
- Eligibility, evaluated in IDLE only:
  - Write is eligible when `wr_req` && !`full`.
  - Read is eligible when `rd_req` && !`empty`.
  - A requester whose ack is asserted in the current cycle is never eligible.
- Arbitration:
  - One eligible requester: grant it.
  - Both eligible: grant the one not served last (`last_wr` flag). After reset `last_wr`=0, so the write wins the first tie.
  - No eligible requester: stay in IDLE.
- On grant: capture `wr_data` into `fifo_in` for writes, set `fifo_wr_rd`, update `last_wr`, go to SETUP.
- SETUP: `fifo_enable`=0 and `fifo_wr_rd` stable.
- ACCESS: `fifo_enable`=1 for exactly one cycle. For a read, `fifo_out` is captured into `rd_data` at the end of ACCESS.
- RESP: pulse `wr_ack` or `rd_ack` for one cycle, then return to IDLE.
- `fifo_wr_rd` holds its value through SETUP, ACCESS and RESP, and keeps its last value in IDLE. It changes only on a grant.
- Level update, at the end of ACCESS: +1 for a write, −1 for a read. No other path changes it. Because the controller is the sole FIFO master, `full`/`empty` cannot change between grant and access, so the level can never overflow or underflow.
- Watermarks are registered from the next `level` value, so they update in the same cycle as `level`.
- `full`/`empty` from the FIFO are authoritative for eligibility. `level` is informational.

## Timing
- Reset values, one cycle after `rst`=1 is sampled:
  - state IDLE
  - `fifo_enable`=0, `fifo_wr_rd`=0, `fifo_old_add_flag`=0
  - `fifo_in`=0, `rd_data`=0
  - `wr_ack`=0, `rd_ack`=0, `busy`=0
  - `level`=0, `above_hi`=0, `below_lo`=1, `last_wr`=0
- Latency: a request sampled in IDLE at edge k gives SETUP in k+1, ACCESS in k+2, ack in k+3. The next grant can occur in cycle k+4 (IDLE). Sustained throughput is 1 word / 4 cycles.
- `rst` asserted mid-transfer, in any state, aborts the transfer:
  - No ack is issued.
  - `level` returns to 0, consistent with the FIFO being reset.
  - Requesters must re-request.
- If a requester drops its request before the ack, the transfer still completes and the ack still pulses. Requesters must not do this.

## Test plan
- Reset, then write 0xA5: `wr_ack` 3 cycles after the grant cycle; `fifo_enable` high for exactly one cycle, one cycle after `fifo_wr_rd`=1; `level`=1, `below_lo`=1.
- Write 0x11, 0x22, 0x33, then three reads: `rd_data` returns 0x11, 0x22, 0x33 with one `rd_ack` each; `level` ends at 0.
- `wr_req` and `rd_req` held continuously with the FIFO non-empty and non-full: grants alternate W, R, W, R…, with the first tie going to the write.
- 16 writes (`full`=1) with `wr_req` still high: no grant, no `fifo_enable`, `level`=16, `above_hi`=1. One read then lets the pending write complete.
- `rd_req` on an empty FIFO: stays in IDLE, `busy`=0, no `rd_ack`. A later write is followed by the read being granted.
- `rst` pulsed during ACCESS of a write: no `wr_ack`; next cycle all outputs are at their reset values, `level`=0, `below_lo`=1.
